// File: rtl/ps2_scancode.sv
// ps2_scancode
// PS/2 keyboard receiver. It synchronizes and filters the raw PS/2 clock and
// frames 11-bit serial words. Scancode bytes are decoded into key events, with
// the E0 (extended) and F0 (release) prefixes folded into flags.
//
// Parameters
//   FILTER_LEN      consecutive equal synchronized ps2_clk samples before the
//                   filtered clock changes level (2-255)
//   TIMEOUT_CYCLES  clk_sys cycles without a bit event, mid-frame, before the
//                   frame is abandoned
//
// Ports
//   clk_sys       in   system clock
//   reset_n       in   asynchronous active-low reset
//   ps2_clk       in   raw PS/2 clock (asynchronous)
//   ps2_data      in   raw PS/2 data (asynchronous)
//   key_strobe    out  one-cycle pulse, new key event valid
//   key_pressed   out  1 = make, 0 = break
//   key_extended  out  1 = E0 prefix preceded the code
//   key_code      out  [7:0] scancode with prefixes stripped
//   frame_err     out  one-cycle pulse on parity, stop-bit or timeout error
//
// Build option
//   PS2_PARITY_CHECK_EN  defined: a parity failure is a bad frame.
//                        undefined: the parity bit is sampled and ignored.
//
// Receiver states
//   state  | meaning
//   IDLE   | waiting for a start bit (data 0 on a bit event)
//   DATA   | shifting in 8 data bits, LSB first
//   PARITY | waiting for the parity bit
//   STOP   | waiting for the stop bit, then judge the frame

module ps2_scancode #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       clk_sys,
  input  logic       reset_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       key_strobe,
  output logic       key_pressed,
  output logic       key_extended,
  output logic [7:0] key_code,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } state_t;

  logic            r_clk_s1, r_clk_s2;
  logic            r_dat_s1, r_dat_s2;
  logic            r_filt_clk, r_filt_prev;
  logic [7:0]      r_filt_cnt;

  state_t          r_state;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic [TO_W-1:0] r_to_cnt;
  logic            r_ext_pend, r_rel_pend;
  logic            r_key_strobe, r_frame_err;
  logic            r_key_pressed, r_key_ext;
  logic [7:0]      r_key_code;
`ifdef PS2_PARITY_CHECK_EN
  logic            r_par;
`endif

  logic w_bit_evt;
  logic w_bit_dat;
  logic w_par_ok;
  logic w_good;

  // Synchronizers and the clock glitch filter. The filtered level flips only
  // after FILTER_LEN consecutive samples disagree with it.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_clk_s1    <= 1'b1;
      r_clk_s2    <= 1'b1;
      r_dat_s1    <= 1'b1;
      r_dat_s2    <= 1'b1;
      r_filt_clk  <= 1'b1;
      r_filt_prev <= 1'b1;
      r_filt_cnt  <= 8'd0;
    end else begin
      r_clk_s1    <= ps2_clk;
      r_clk_s2    <= r_clk_s1;
      r_dat_s1    <= ps2_data;
      r_dat_s2    <= r_dat_s1;
      r_filt_prev <= r_filt_clk;
      if (r_clk_s2 == r_filt_clk) begin
        r_filt_cnt <= 8'd0;
      end else if (r_filt_cnt == 8'(FILTER_LEN - 1)) begin
        r_filt_clk <= r_clk_s2;
        r_filt_cnt <= 8'd0;
      end else begin
        r_filt_cnt <= r_filt_cnt + 8'd1;
      end
    end
  end

  // Falling edge of the filtered clock; data is long settled by then because
  // the filter delays the clock by FILTER_LEN cycles relative to data.
  assign w_bit_evt = r_filt_prev & ~r_filt_clk;
  assign w_bit_dat = r_dat_s2;

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, r_par};
`else
  assign w_par_ok = 1'b1;
`endif

  assign w_good = w_bit_dat & w_par_ok;

  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_to_cnt      <= '0;
      r_ext_pend    <= 1'b0;
      r_rel_pend    <= 1'b0;
      r_key_strobe  <= 1'b0;
      r_frame_err   <= 1'b0;
      r_key_pressed <= 1'b0;
      r_key_ext     <= 1'b0;
      r_key_code    <= 8'h00;
`ifdef PS2_PARITY_CHECK_EN
      r_par         <= 1'b0;
`endif
    end else begin
      r_key_strobe <= 1'b0;
      r_frame_err  <= 1'b0;
      if (r_state == IDLE) begin
        r_to_cnt <= '0;
        if (w_bit_evt && !w_bit_dat) begin
          r_state   <= DATA;
          r_bit_cnt <= 3'd0;
        end
      end else if (w_bit_evt) begin
        r_to_cnt <= '0;
        case (r_state)
          DATA: begin
            r_shift <= {w_bit_dat, r_shift[7:1]};
            if (r_bit_cnt == 3'd7) begin
              r_state <= PARITY;
            end else begin
              r_bit_cnt <= r_bit_cnt + 3'd1;
            end
          end
          PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
            r_par <= w_bit_dat;
`endif
            r_state <= STOP;
          end
          default: begin
            r_state <= IDLE;
            if (!w_good) begin
              r_frame_err <= 1'b1;
              r_ext_pend  <= 1'b0;
              r_rel_pend  <= 1'b0;
            end else if (r_shift == 8'hE0) begin
              r_ext_pend <= 1'b1;
            end else if (r_shift == 8'hF0) begin
              r_rel_pend <= 1'b1;
            end else begin
              r_key_strobe  <= 1'b1;
              r_key_code    <= r_shift;
              r_key_ext     <= r_ext_pend;
              r_key_pressed <= ~r_rel_pend;
              r_ext_pend    <= 1'b0;
              r_rel_pend    <= 1'b0;
            end
          end
        endcase
      end else if (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1)) begin
        // Device stalled mid-frame: drop the partial byte and any prefixes.
        r_state     <= IDLE;
        r_to_cnt    <= '0;
        r_frame_err <= 1'b1;
        r_ext_pend  <= 1'b0;
        r_rel_pend  <= 1'b0;
      end else begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
    end
  end

  assign key_strobe   = r_key_strobe;
  assign frame_err    = r_frame_err;
  assign key_code     = r_key_code;
  assign key_pressed  = r_key_pressed;
  assign key_extended = r_key_ext;

endmodule

// File: tb/tb_ps2_scancode.sv
// tb_ps2_scancode
// Bench for ps2_scancode. It drives PS/2 frames bit by bit, including
// directed cases and a randomized stream, and compares the key events with a
// frame-level model of the scancode protocol.

module tb_ps2_scancode;

  localparam int FL = 4;
  localparam int TO = 400;
`ifdef PS2_PARITY_CHECK_EN
  localparam bit PCHK = 1'b1;
`else
  localparam bit PCHK = 1'b0;
`endif

  logic       clk_sys  = 1'b0;
  logic       reset_n  = 1'b0;
  logic       ps2_clk  = 1'b1;
  logic       ps2_data = 1'b1;
  logic       key_strobe, key_pressed, key_extended, frame_err;
  logic [7:0] key_code;

  int n_vec = 0;
  int n_bad = 0;
  int n_strobe = 0;
  int n_ferr = 0;

  // model state: pending prefixes and the last reported key
  bit         m_ext = 0, m_rel = 0;
  logic [7:0] m_code = 8'h00;
  bit         m_pressed = 0, m_extd = 0;

  ps2_scancode #(.FILTER_LEN(FL), .TIMEOUT_CYCLES(TO)) dut (
    .clk_sys      (clk_sys),
    .reset_n      (reset_n),
    .ps2_clk      (ps2_clk),
    .ps2_data     (ps2_data),
    .key_strobe   (key_strobe),
    .key_pressed  (key_pressed),
    .key_extended (key_extended),
    .key_code     (key_code),
    .frame_err    (frame_err)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk_sys) begin
    if (reset_n) begin
      if (key_strobe) n_strobe++;
      if (frame_err) n_ferr++;
      if (key_strobe || frame_err) chk("strobe_err_excl", 32'(key_strobe & frame_err), 0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk_sys);
  endtask

  // one PS/2 bit: data set mid-high, 20-cycle low, 20-cycle high; optional
  // single-cycle glitches in both phases
  task automatic send_bit(input bit d, input bit gl);
    ps2_data = d;
    cyc(10);
    ps2_clk = 1'b0;
    if (gl) begin
      cyc(8); ps2_clk = 1'b1; cyc(1); ps2_clk = 1'b0; cyc(11);
    end else begin
      cyc(20);
    end
    ps2_clk = 1'b1;
    if (gl) begin
      cyc(4); ps2_clk = 1'b0; cyc(1); ps2_clk = 1'b1; cyc(5);
    end else begin
      cyc(10);
    end
  endtask

  task automatic frame(input string tag, input logic [7:0] b, input bit par_ok,
                       input bit stop, input bit gl);
    int  s0, e0, exp_s, exp_e;
    bit  good;
    s0 = n_strobe;
    e0 = n_ferr;
    send_bit(1'b0, gl);
    for (int i = 0; i < 8; i++) send_bit(b[i], gl);
    send_bit(par_ok ? ~(^b) : ^b, gl);
    send_bit(stop, gl);
    ps2_data = 1'b1;
    cyc(20);
    exp_s = 0;
    exp_e = 0;
    good = stop && (par_ok || !PCHK);
    if (!good) begin
      exp_e = 1; m_ext = 0; m_rel = 0;
    end else if (b == 8'hE0) begin
      m_ext = 1;
    end else if (b == 8'hF0) begin
      m_rel = 1;
    end else begin
      exp_s = 1; m_code = b; m_pressed = !m_rel; m_extd = m_ext;
      m_ext = 0; m_rel = 0;
    end
    chk({tag, "_strobes"}, n_strobe - s0, exp_s);
    chk({tag, "_errs"}, n_ferr - e0, exp_e);
    chk({tag, "_code"}, key_code, m_code);
    chk({tag, "_pressed"}, key_pressed, m_pressed);
    chk({tag, "_ext"}, key_extended, m_extd);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, e0, r;
    logic [7:0] b;
    cyc(5);
    chk("rst_strobe", key_strobe, 0);
    chk("rst_err", frame_err, 0);
    chk("rst_code", key_code, 8'h00);
    chk("rst_pressed", key_pressed, 0);
    chk("rst_ext", key_extended, 0);
    reset_n = 1'b1;
    cyc(10);

    frame("make_1C", 8'h1C, 1, 1, 0);
    frame("rel_F0", 8'hF0, 1, 1, 0);
    frame("rel_1C", 8'h1C, 1, 1, 0);
    frame("ext_E0", 8'hE0, 1, 1, 0);
    frame("ext_F0", 8'hF0, 1, 1, 0);
    frame("ext_6B", 8'h6B, 1, 1, 0);
    frame("plain_6B", 8'h6B, 1, 1, 0);
    frame("ord_F0", 8'hF0, 1, 1, 0);
    frame("ord_E0", 8'hE0, 1, 1, 0);
    frame("ord_75", 8'h75, 1, 1, 0);
    frame("badpar_5A", 8'h5A, 0, 1, 0);
    frame("pre_F0", 8'hF0, 1, 1, 0);
    frame("badstop_1C", 8'h1C, 1, 0, 0);
    frame("after_stop_1C", 8'h1C, 1, 1, 0);

    // timeout: prefix pending, then a start bit and 4 data bits and silence
    frame("to_pre_E0", 8'hE0, 1, 1, 0);
    s0 = n_strobe;
    e0 = n_ferr;
    send_bit(1'b0, 0);
    for (int i = 0; i < 4; i++) send_bit(i[0], 0);
    ps2_data = 1'b1;
    cyc(TO + 100);
    chk("timeout_errs", n_ferr - e0, 1);
    chk("timeout_strobes", n_strobe - s0, 0);
    m_ext = 0; m_rel = 0;
    frame("after_to_29", 8'h29, 1, 1, 0);

    frame("glitch_16", 8'h16, 1, 1, 1);

    // reset mid-frame
    s0 = n_strobe;
    e0 = n_ferr;
    send_bit(1'b0, 0);
    for (int i = 0; i < 3; i++) send_bit(1'b1, 0);
    reset_n = 1'b0;
    cyc(3);
    chk("midrst_code", key_code, 8'h00);
    chk("midrst_pressed", key_pressed, 0);
    reset_n = 1'b1;
    cyc(60);
    chk("midrst_strobes", n_strobe - s0, 0);
    chk("midrst_errs", n_ferr - e0, 0);
    m_ext = 0; m_rel = 0; m_code = 8'h00; m_pressed = 0; m_extd = 0;
    frame("after_rst_16", 8'h16, 1, 1, 0);

    for (int k = 0; k < 40; k++) begin
      r = $urandom_range(0, 9);
      if (r == 0) b = 8'hE0;
      else if (r == 1) b = 8'hF0;
      else b = 8'($urandom_range(0, 255));
      frame("rand", b, $urandom_range(0, 7) != 0, $urandom_range(0, 9) != 0,
            $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_scancode.md
PS2_SCANCODE -- requirements
Module: ps2_scancode

Interface
REQ-001 Parameter FILTER_LEN, default 8: consecutive identical synchronized ps2_clk samples needed before the filtered clock level changes (range 2-255).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: clk_sys cycles without a filtered ps2_clk falling edge, mid-frame, after which the frame is abandoned.
REQ-003 clk_sys  input  1  system clock; only clock.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 ps2_clk  input  1  raw PS/2 clock from device, asynchronous to clk_sys.
REQ-006 ps2_data  input  1  raw PS/2 data, asynchronous to clk_sys.
REQ-007 key_strobe  output  1  one-cycle pulse: new key event valid.
REQ-008 key_pressed  output  1  1 = make, 0 = break (F0 prefix seen).
REQ-009 key_extended  output  1  1 = E0 prefix preceded code.
REQ-010 key_code  output  8  scancode byte, prefixes stripped.
REQ-011 frame_err  output  1  one-cycle pulse on parity, stop-bit or timeout error.

Function
REQ-012 ps2_clk and ps2_data SHALL each pass through a 2-flop synchronizer before any use.
REQ-013 The filtered clock SHALL take the synchronized ps2_clk value only after FILTER_LEN consecutive equal samples; a falling edge of the filtered clock is a "bit event", and ps2_data (synchronized) is sampled on that cycle.
REQ-014 Receiver FSM states: IDLE, DATA, PARITY, STOP.
REQ-015 IDLE: on a bit event with data 0 (start bit) go to DATA and clear the bit counter; a bit event with data 1 stays in IDLE, no error.
REQ-016 DATA: shift in 8 bits LSB first on 8 bit events (counter 0-7), then go to PARITY.
REQ-017 PARITY: sample parity bit; go to STOP.
REQ-018 STOP: sample stop bit; a frame is good if stop=1 and the 9 bits (data+parity) have odd parity; always return to IDLE.
REQ-019 Timeout counter SHALL clear on every bit event and in IDLE; reaching TIMEOUT_CYCLES in DATA/PARITY/STOP forces IDLE, discards partial byte, pulses frame_err, clears both prefix flags.
REQ-020 Good byte 0xE0 SHALL set ext_pend; 0xF0 SHALL set rel_pend; neither produces key_strobe.
REQ-021 Any other good byte B: on the cycle after the STOP bit event, key_strobe=1, key_code=B, key_extended=ext_pend, key_pressed=~rel_pend; both flags clear in that same cycle.
REQ-022 key_code, key_pressed and key_extended SHALL hold their values until the next key_strobe.
REQ-023 Bad frame (stop=0, or parity fail when checked): no key_strobe, frame_err pulses on the cycle after the STOP bit event, both prefix flags clear.
REQ-024 Sequence E0 F0 B SHALL yield one strobe with extended=1, pressed=0; F0 E0 B SHALL yield the same result (flag order irrelevant).
REQ-025 key_strobe and frame_err SHALL never be asserted in the same cycle; at most one event per frame.

Reset
REQ-026 While reset_n=0: FSM=IDLE, counters=0, filtered clock=1, synchronizers=1, prefix flags=0, key_strobe=0, frame_err=0, key_code=8'h00, key_pressed=0, key_extended=0.
REQ-027 Reset asserted mid-frame SHALL discard the frame; after release the next start bit begins a fresh frame.

Configuration
REQ-028 Macro PS2_PARITY_CHECK_EN defined: parity fail is a bad frame per REQ-023.
REQ-029 PS2_PARITY_CHECK_EN undefined: parity bit is sampled and ignored; only the stop bit and the timeout produce errors.

Verification
REQ-030 Frame 0x1C (A), correct parity, stop=1 -> one key_strobe, key_code=8'h1C, key_pressed=1, key_extended=0.
REQ-031 Frames F0,1C -> one strobe, key_code=8'h1C, key_pressed=0; no strobe after the F0 frame.
REQ-032 Frames E0,F0,6B -> one strobe, key_code=8'h6B, key_extended=1, key_pressed=0; next frame 6B -> key_extended=0, key_pressed=1.
REQ-033 Frame 0x5A with wrong parity -> with PS2_PARITY_CHECK_EN: frame_err pulse, no strobe; without: strobe, key_code=8'h5A.
REQ-034 Start bit plus 4 data bits, then idle for TIMEOUT_CYCLES -> frame_err pulse, FSM IDLE; following 0x29 frame -> strobe, key_code=8'h29.
REQ-035 1-cycle ps2_clk glitches (shorter than FILTER_LEN) injected during a 0x16 frame -> no extra bit events, strobe with key_code=8'h16; reset_n pulsed mid-frame -> no strobe and no frame_err for that frame.
